// File: rtl/aap_fetch_pkg.sv
// aap_fetch_pkg: shared types and helpers for the AAP instruction fetch stage.
//   asm_state_e : instruction assembler state (expecting first or second half)
//   is_32bit()  : classifies a halfword as the first half of a 32-bit instruction
//   AAP_PC_W    : default program counter / halfword address width
package aap_fetch_pkg;

  localparam int unsigned AAP_PC_W = 24;

  typedef enum logic {
    ASM_LO, // next halfword starts an instruction
    ASM_HI  // next halfword completes a 32-bit instruction
  } asm_state_e;

  // Bit 15 set marks the first half of a 32-bit instruction.
  function automatic logic is_32bit(input logic [15:0] hw);
    return hw[15];
  endfunction

endpackage

// File: rtl/aap_fetch_if.sv
// aap_fetch_if: fetch-to-decoder instruction handshake.
//   out_valid : instruction available (fetch -> decoder)
//   out_ready : decoder accepts this cycle (decoder -> fetch)
//   out_instr : {16'h0,hw} for 16-bit, {hw_second,hw_first} for 32-bit
//   out_is32  : instruction is 32-bit
//   out_pc    : halfword address of the first half
// Modports: master = fetch stage, slave = decoder.
interface aap_fetch_if import aap_fetch_pkg::*; #(
  parameter int unsigned PC_W = AAP_PC_W
);

  logic            out_valid;
  logic            out_ready;
  logic [31:0]     out_instr;
  logic            out_is32;
  logic [PC_W-1:0] out_pc;

  modport master (
    output out_valid, out_instr, out_is32, out_pc,
    input  out_ready
  );

  modport slave (
    input  out_valid, out_instr, out_is32, out_pc,
    output out_ready
  );

endinterface

// File: rtl/aap_halfword_fifo.sv
// aap_halfword_fifo: 2-entry 16-bit skid FIFO between program memory and
// the instruction assembler.
//   clock, reset : rising-edge clock, asynchronous active-low reset
//   flush        : synchronous clear (branch redirect)
//   push/push_data, pop/pop_data : write and read ports; pop_data shows the head
//   count        : number of valid entries (0..2)
// The caller never pushes into a full FIFO or pops an empty one.
module aap_halfword_fifo (
  input  logic        clock,
  input  logic        reset,
  input  logic        flush,
  input  logic        push,
  input  logic [15:0] push_data,
  input  logic        pop,
  output logic [15:0] pop_data,
  output logic [1:0]  count
);

  logic [15:0] store [2];
  logic        wr_ptr;
  logic        rd_ptr;

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge values of the others.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else if (flush) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push) wr_ptr <= ~wr_ptr;
      if (pop)  rd_ptr <= ~rd_ptr;
      count <= count + 2'(push) - 2'(pop);
    end
  end

  // NOTE: the data storage is deliberately not reset; count alone decides
  // which entries are meaningful.
  always_ff @(posedge clock) begin
    if (push && !flush) store[wr_ptr] <= push_data;
  end

  assign pop_data = store[rd_ptr];

endmodule

// File: rtl/aap_fetch.sv
// aap_fetch: AAP instruction fetch stage.
// Issues halfword reads to synchronous program memory, buffers returned
// halfwords in a 2-entry skid FIFO, assembles 16/32-bit instructions and
// hands them to the decoder. A branch redirect flushes all wrong-path state.
//   clock, reset        : rising-edge clock, asynchronous active-low reset
//   imem_en, imem_addr  : read request and halfword address (this cycle)
//   imem_rdata          : read data, valid the cycle after imem_en
//   branch_valid/target : redirect fetch; highest priority
//   dec (master)        : out_valid/out_ready/out_instr/out_is32/out_pc
module aap_fetch import aap_fetch_pkg::*; #(
  parameter int unsigned     PC_W     = AAP_PC_W,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic            clock,
  input  logic            reset,
  output logic            imem_en,
  output logic [PC_W-1:0] imem_addr,
  input  logic [15:0]     imem_rdata,
  input  logic            branch_valid,
  input  logic [PC_W-1:0] branch_target,
  aap_fetch_if.master     dec
);

  logic [PC_W-1:0] fetch_pc;  // next address to request
  logic [PC_W-1:0] asm_pc;    // address of the next halfword the assembler takes
  logic [PC_W-1:0] hi_pc;     // address of the held first half
  logic [15:0]     hi_hw;     // held first half of a 32-bit instruction
  logic            inflight;  // a request issued last cycle returns now
  asm_state_e      asm_state;

  logic [1:0]  fifo_count;
  logic [15:0] fifo_head;
  logic        fifo_push;
  logic        fifo_pop;
  logic        use_fifo;
  logic        consume;
  logic [15:0] hw;
  logic [2:0]  credit;

  // NOTE: every always_comb output is assigned on every path, so no latch
  // can be inferred.
  always_comb begin
    use_fifo  = (fifo_count != 2'd0);
    // The assembler takes a halfword only if the output register is free
    // or being drained this cycle; a branch cancels everything.
    consume   = !branch_valid && (!dec.out_valid || dec.out_ready) &&
                (use_fifo || inflight);
    // Oldest data first: FIFO head, otherwise bypass the returning halfword.
    hw        = use_fifo ? fifo_head : imem_rdata;
    fifo_pop  = consume && use_fifo;
    fifo_push = !branch_valid && inflight && !(consume && !use_fifo);
    // A consumed halfword, popped or bypassed, frees a slot this cycle.
    // fifo_count + inflight never exceeds 2, so this cannot underflow.
    credit    = 3'd2 - 3'(fifo_count) - 3'(inflight) + 3'(consume);
    // Gated by reset so no request is presented while held in reset.
    imem_en   = reset && !branch_valid && (credit != 3'd0);
    imem_addr = fetch_pc;
  end

  aap_halfword_fifo u_fifo (
    .clock     (clock),
    .reset     (reset),
    .flush     (branch_valid),
    .push      (fifo_push),
    .push_data (imem_rdata),
    .pop       (fifo_pop),
    .pop_data  (fifo_head),
    .count     (fifo_count)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      fetch_pc      <= RESET_PC;
      asm_pc        <= RESET_PC;
      hi_pc         <= '0;
      hi_hw         <= 16'h0;
      inflight      <= 1'b0;
      asm_state     <= ASM_LO;
      dec.out_valid <= 1'b0;
      dec.out_instr <= 32'h0;
      dec.out_is32  <= 1'b0;
      dec.out_pc    <= '0;
    end else if (branch_valid) begin
      // Returning rdata and any held first half are wrong-path: drop them.
      fetch_pc      <= branch_target;
      asm_pc        <= branch_target;
      inflight      <= 1'b0;
      asm_state     <= ASM_LO;
      dec.out_valid <= 1'b0;
    end else begin
      inflight <= imem_en;
      if (imem_en) fetch_pc <= fetch_pc + PC_W'(1);

      if (consume) begin
        asm_pc <= asm_pc + PC_W'(1);
        case (asm_state)
          ASM_LO: begin
            if (is_32bit(hw)) begin
              hi_hw         <= hw;
              hi_pc         <= asm_pc;
              asm_state     <= ASM_HI;
              dec.out_valid <= 1'b0;
            end else begin
              dec.out_valid <= 1'b1;
              dec.out_instr <= {16'h0, hw};
              dec.out_is32  <= 1'b0;
              dec.out_pc    <= asm_pc;
            end
          end
          ASM_HI: begin
            dec.out_valid <= 1'b1;
            dec.out_instr <= {hw, hi_hw};
            dec.out_is32  <= 1'b1;
            dec.out_pc    <= hi_pc;
            asm_state     <= ASM_LO;
          end
        endcase
      end else if (dec.out_ready) begin
        dec.out_valid <= 1'b0;
      end
    end
  end

endmodule
